scan_ascii_decoder: RTL and testbench

SCAN_ASCII_DECODER -- requirements
Module: scan_ascii_decoder

---
 rtl/scan_pkg.sv | 69 ++++++
 rtl/scan_ascii_decoder_if.sv | 26 ++
 rtl/char_fifo.sv | 73 +++++++
 rtl/scan_ascii_decoder.sv | 124 ++++++++++++
 tb/tb_scan_ascii_decoder.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/scan_pkg.sv
// Shared types, scan-code constants and lookup tables for the PS/2 set-2
// scan-code to ASCII decoder.
package scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK
  } state_t;

  localparam logic [7:0] PFX_BRK     = 8'hF0;
  localparam logic [7:0] PFX_EXT     = 8'hE0;

  localparam logic [7:0] CODE_LSHIFT = 8'h12;
  localparam logic [7:0] CODE_RSHIFT = 8'h59;
  localparam logic [7:0] CODE_CAPS   = 8'h58;
  localparam logic [7:0] CODE_SPACE  = 8'h29;
  localparam logic [7:0] CODE_ENTER  = 8'h5A;
  localparam logic [7:0] CODE_BKSP   = 8'h66;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_UPPER = 8'h41;
  localparam logic [7:0] ASCII_LOWER = 8'h61;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  // Index 0 is 'A' / '0'; the ASCII value is the base plus the table index.
  localparam logic [0:25][7:0] LETTER_CODES = {
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
    8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A
  };

  localparam logic [0:9][7:0] DIGIT_CODES = {
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46
  };

  typedef struct packed {
    logic       hit;
    logic [7:0] ch;
  } char_map_t;

  function automatic char_map_t mapMake(input logic [7:0] code, input logic upper);
    char_map_t m;
    m = '0;
    for (int i = 0; i < 26; i++) begin
      if (code == LETTER_CODES[i]) begin
        m.hit = 1'b1;
        m.ch  = (upper ? ASCII_UPPER : ASCII_LOWER) + 8'(i);
      end
    end
    for (int i = 0; i < 10; i++) begin
      if (code == DIGIT_CODES[i]) begin
        m.hit = 1'b1;
        m.ch  = ASCII_ZERO + 8'(i);
      end
    end
    case (code)
      CODE_SPACE: begin m.hit = 1'b1; m.ch = ASCII_SPACE; end
      CODE_ENTER: begin m.hit = 1'b1; m.ch = ASCII_CR;    end
      CODE_BKSP:  begin m.hit = 1'b1; m.ch = ASCII_BS;    end
      default: ;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/scan_ascii_decoder_if.sv
// Scan-byte input, character output and status bundle of the decoder.
interface scan_ascii_decoder_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    scan_code;
  logic          scan_valid;
  logic [7:0]    ascii_data;
  logic          ascii_valid;
  logic          ascii_ready;
  logic          shift_active;
  logic          caps_lock;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  modport master (
    output scan_code, scan_valid, ascii_ready,
    input  ascii_data, ascii_valid, shift_active, caps_lock, fifo_count, overflow
  );

  modport slave (
    input  scan_code, scan_valid, ascii_ready,
    output ascii_data, ascii_valid, shift_active, caps_lock, fifo_count, overflow
  );
endinterface

// File: rtl/char_fifo.sv
// First-word-fall-through character FIFO with sticky overflow; a push
// into a full FIFO succeeds only when a pop happens in the same cycle.
module char_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_valid,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;
  logic             r_overflow;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_FULL);
  assign w_pop   = i_pop & ~w_empty;
  assign w_push  = i_push & (~w_full | w_pop);
  assign w_drop  = i_push & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= i_data;
    end
  end

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_data     = w_empty ? '0 : r_mem[r_rdPtr];
  assign o_valid    = ~w_empty;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;
endmodule

// File: rtl/scan_ascii_decoder.sv
// PS/2 set-2 scan-code decoder: tracks break/extended prefixes, Shift and
// Caps Lock, and queues the resulting ASCII characters in a char_fifo.
module scan_ascii_decoder
  import scan_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter bit CAPS_EN    = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  scan_ascii_decoder_if.slave bus
);
  state_t    r_state;
  state_t    w_nextState;
  logic      r_lshift;
  logic      r_rshift;
  logic      r_caps;

  logic      w_setL;
  logic      w_clrL;
  logic      w_setR;
  logic      w_clrR;
  logic      w_toggleCaps;
  logic      w_push;
  logic [7:0] w_pushData;
  logic      w_upper;
  char_map_t w_map;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Case uses the shift/caps state registered before this byte arrived.
  always_comb begin
    w_nextState  = r_state;
    w_setL       = 1'b0;
    w_clrL       = 1'b0;
    w_setR       = 1'b0;
    w_clrR       = 1'b0;
    w_toggleCaps = 1'b0;
    w_push       = 1'b0;
    w_pushData   = '0;
    w_upper      = (r_lshift | r_rshift) ^ r_caps;
    w_map        = mapMake(bus.scan_code, w_upper);
    if (bus.scan_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (bus.scan_code == PFX_BRK) begin
            w_nextState = ST_BRK;
          end else if (bus.scan_code == PFX_EXT) begin
            w_nextState = ST_EXT;
          end else if (bus.scan_code == CODE_LSHIFT) begin
            w_setL = 1'b1;
          end else if (bus.scan_code == CODE_RSHIFT) begin
            w_setR = 1'b1;
          end else if (bus.scan_code == CODE_CAPS) begin
            w_toggleCaps = CAPS_EN;
          end else if (w_map.hit) begin
            w_push     = 1'b1;
            w_pushData = w_map.ch;
          end
        end
        ST_BRK: begin
          w_nextState = ST_IDLE;
          w_clrL      = (bus.scan_code == CODE_LSHIFT);
          w_clrR      = (bus.scan_code == CODE_RSHIFT);
        end
        ST_EXT: begin
          w_nextState = (bus.scan_code == PFX_BRK) ? ST_EXT_BRK : ST_IDLE;
        end
        ST_EXT_BRK: begin
          w_nextState = ST_IDLE;
        end
        default: begin
          w_nextState = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lshift <= 1'b0;
      r_rshift <= 1'b0;
      r_caps   <= 1'b0;
    end else begin
      if (w_setL) begin
        r_lshift <= 1'b1;
      end else if (w_clrL) begin
        r_lshift <= 1'b0;
      end
      if (w_setR) begin
        r_rshift <= 1'b1;
      end else if (w_clrR) begin
        r_rshift <= 1'b0;
      end
      if (w_toggleCaps) begin
        r_caps <= ~r_caps;
      end
    end
  end

  assign bus.shift_active = r_lshift | r_rshift;
  assign bus.caps_lock    = r_caps;

  char_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_push),
    .i_data     (w_pushData),
    .i_pop      (bus.ascii_ready),
    .o_data     (bus.ascii_data),
    .o_valid    (bus.ascii_valid),
    .o_count    (bus.fifo_count),
    .o_overflow (bus.overflow)
  );
endmodule

// File: tb/tb_scan_ascii_decoder.sv
// Self-checking bench for scan_ascii_decoder: directed vector table, hand
// sequences for overflow and reset, then random bytes against a queue model.
module tb_scan_ascii_decoder;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  scan_ascii_decoder_if #(.FIFO_DEPTH(DEPTH)) bus ();

  scan_ascii_decoder #(
    .FIFO_DEPTH (DEPTH),
    .CAPS_EN    (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  logic       mLeft, mRight, mCaps, mOver;
  logic [7:0] mFifo[$];
  logic [7:0] mPfx[$];

  logic [7:0] letterCodes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digitCodes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
    8'h3D, 8'h3E, 8'h46};
  logic [7:0] pool [20] = '{8'h1C, 8'h32, 8'h1A, 8'h4D, 8'h45, 8'h46, 8'h16, 8'h12,
    8'h59, 8'h58, 8'hF0, 8'hF0, 8'hE0, 8'h29, 8'h5A, 8'h66, 8'h76, 8'h75, 8'h12, 8'h2B};

  typedef struct {
    logic       v;
    logic [7:0] code;
    logic       r;
    logic       expValid;
    logic [7:0] expData;
    int         expCount;
    logic       expShift;
    logic       expCaps;
  } vec_t;
  vec_t vecs[$];

  function automatic int findIdx(input logic [7:0] c, input bit letters);
    int res;
    res = -1;
    if (letters) begin
      for (int i = 0; i < 26; i++) if (letterCodes[i] == c) res = i;
    end else begin
      for (int i = 0; i < 10; i++) if (digitCodes[i] == c) res = i;
    end
    return res;
  endfunction

  function automatic void modelReset();
    mLeft = 1'b0; mRight = 1'b0; mCaps = 1'b0; mOver = 1'b0;
    mFifo.delete();
    mPfx.delete();
  endfunction

  // Keyboard rules applied to one cycle of inputs, with the FIFO as a queue.
  function automatic void modelStep(input logic v, input logic [7:0] c, input logic r);
    logic       doPush, doPop, upper;
    logic [7:0] ch;
    int         li, di;
    doPush = 1'b0;
    ch     = 8'h00;
    doPop  = r && (mFifo.size() > 0);
    upper  = (mLeft | mRight) ^ mCaps;
    if (v) begin
      if (mPfx.size() == 0) begin
        li = findIdx(c, 1'b1);
        di = findIdx(c, 1'b0);
        if (c == 8'hF0 || c == 8'hE0) mPfx.push_back(c);
        else if (c == 8'h12) mLeft = 1'b1;
        else if (c == 8'h59) mRight = 1'b1;
        else if (c == 8'h58) mCaps = ~mCaps;
        else if (li >= 0) begin doPush = 1'b1; ch = upper ? 8'(65 + li) : 8'(97 + li); end
        else if (di >= 0) begin doPush = 1'b1; ch = 8'(48 + di); end
        else if (c == 8'h29) begin doPush = 1'b1; ch = 8'h20; end
        else if (c == 8'h5A) begin doPush = 1'b1; ch = 8'h0D; end
        else if (c == 8'h66) begin doPush = 1'b1; ch = 8'h08; end
      end else if (mPfx[0] == 8'hF0) begin
        if (c == 8'h12) mLeft = 1'b0;
        if (c == 8'h59) mRight = 1'b0;
        mPfx.delete();
      end else if (mPfx.size() == 1 && c == 8'hF0) begin
        mPfx.push_back(c);
      end else begin
        mPfx.delete();
      end
    end
    if (doPush && !doPop && mFifo.size() == DEPTH) begin
      mOver = 1'b1;
    end else begin
      if (doPop) void'(mFifo.pop_front());
      if (doPush) mFifo.push_back(ch);
    end
  endfunction

  task automatic cmp(input string name, input string field, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s %s: got 0x%0h, expected 0x%0h", name, field, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic ev, input logic [7:0] ed,
                             input int ec, input logic es, input logic eca, input logic eo);
    cmp(name, "ascii_valid",  32'(bus.ascii_valid),  32'(ev));
    cmp(name, "ascii_data",   32'(bus.ascii_data),   32'(ed));
    cmp(name, "fifo_count",   32'(bus.fifo_count),   32'(ec));
    cmp(name, "shift_active", 32'(bus.shift_active), 32'(es));
    cmp(name, "caps_lock",    32'(bus.caps_lock),    32'(eca));
    cmp(name, "overflow",     32'(bus.overflow),     32'(eo));
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, mFifo.size() > 0, (mFifo.size() > 0) ? mFifo[0] : 8'h00,
                mFifo.size(), mLeft | mRight, mCaps, mOver);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic applyStimulus(input logic v, input logic [7:0] c, input logic r);
    bus.scan_valid  = v;
    bus.scan_code   = c;
    bus.ascii_ready = r;
    modelStep(v, c, r);
    @(negedge clk);
  endtask

  task automatic doReset(input string name);
    reset           = 1'b1;
    bus.scan_valid  = 1'b0;
    bus.scan_code   = 8'h00;
    bus.ascii_ready = 1'b0;
    #1;
    checkOutput(name, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0);
    modelReset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic void addVec(input logic v, input logic [7:0] c, input logic r,
                                 input logic ev, input logic [7:0] ed, input int ec,
                                 input logic es, input logic eca);
    vec_t t;
    t = '{v, c, r, ev, ed, ec, es, eca};
    vecs.push_back(t);
  endfunction

  logic [7:0] ovCodes [6] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};
  int         ovCount [6] = '{1, 2, 3, 4, 4, 4};
  logic [7:0] ovHead  [6] = '{8'h61, 8'h61, 8'h61, 8'h61, 8'h61, 8'h62};
  logic [7:0] drHead  [4] = '{8'h63, 8'h64, 8'h66, 8'h00};

  initial begin
    // v code r | valid data count shift caps
    addVec(1, 8'h1C, 0, 1, 8'h61, 1, 0, 0);
    addVec(1, 8'h12, 1, 0, 8'h00, 0, 1, 0);
    addVec(1, 8'h1C, 0, 1, 8'h41, 1, 1, 0);
    addVec(1, 8'hF0, 0, 1, 8'h41, 1, 1, 0);
    addVec(1, 8'h12, 0, 1, 8'h41, 1, 0, 0);
    addVec(1, 8'h1C, 0, 1, 8'h41, 2, 0, 0);
    addVec(0, 8'h00, 1, 1, 8'h61, 1, 0, 0);
    addVec(0, 8'h00, 1, 0, 8'h00, 0, 0, 0);
    addVec(1, 8'h58, 0, 0, 8'h00, 0, 0, 1);
    addVec(1, 8'hF0, 0, 0, 8'h00, 0, 0, 1);
    addVec(1, 8'h58, 0, 0, 8'h00, 0, 0, 1);
    addVec(1, 8'h1C, 0, 1, 8'h41, 1, 0, 1);
    addVec(1, 8'h12, 0, 1, 8'h41, 1, 1, 1);
    addVec(1, 8'h1C, 0, 1, 8'h41, 2, 1, 1);
    addVec(0, 8'h00, 1, 1, 8'h61, 1, 1, 1);
    addVec(0, 8'h00, 1, 0, 8'h00, 0, 1, 1);
    addVec(1, 8'hF0, 0, 0, 8'h00, 0, 1, 1);
    addVec(1, 8'h12, 0, 0, 8'h00, 0, 0, 1);
    addVec(1, 8'h58, 0, 0, 8'h00, 0, 0, 0);
    addVec(1, 8'hE0, 0, 0, 8'h00, 0, 0, 0);
    addVec(1, 8'h75, 0, 0, 8'h00, 0, 0, 0);
    addVec(1, 8'hE0, 0, 0, 8'h00, 0, 0, 0);
    addVec(1, 8'hF0, 0, 0, 8'h00, 0, 0, 0);
    addVec(1, 8'h75, 0, 0, 8'h00, 0, 0, 0);
    addVec(1, 8'h16, 0, 1, 8'h31, 1, 0, 0);
    addVec(0, 8'h00, 1, 0, 8'h00, 0, 0, 0);
    addVec(0, 8'h00, 1, 0, 8'h00, 0, 0, 0);
    addVec(1, 8'h59, 0, 0, 8'h00, 0, 1, 0);
    addVec(1, 8'h45, 0, 1, 8'h30, 1, 1, 0);
    addVec(1, 8'hF0, 0, 1, 8'h30, 1, 1, 0);
    addVec(1, 8'h59, 0, 1, 8'h30, 1, 0, 0);
    addVec(1, 8'h29, 0, 1, 8'h30, 2, 0, 0);
    addVec(1, 8'h5A, 0, 1, 8'h30, 3, 0, 0);
    addVec(1, 8'h66, 0, 1, 8'h30, 4, 0, 0);
    addVec(0, 8'h00, 1, 1, 8'h20, 3, 0, 0);
    addVec(0, 8'h00, 1, 1, 8'h0D, 2, 0, 0);
    addVec(0, 8'h00, 1, 1, 8'h08, 1, 0, 0);
    addVec(0, 8'h00, 1, 0, 8'h00, 0, 0, 0);
    addVec(1, 8'hF0, 0, 0, 8'h00, 0, 0, 0);
    addVec(1, 8'h1C, 0, 0, 8'h00, 0, 0, 0);
    addVec(1, 8'h76, 0, 0, 8'h00, 0, 0, 0);
    addVec(1, 8'hE0, 0, 0, 8'h00, 0, 0, 0);
    addVec(1, 8'h1C, 0, 0, 8'h00, 0, 0, 0);
    addVec(1, 8'h1C, 0, 1, 8'h61, 1, 0, 0);
    addVec(0, 8'h00, 1, 0, 8'h00, 0, 0, 0);

    doReset("reset");
    @(negedge clk);

    $display("[TB] directed vectors: %0d", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].v, vecs[i].code, vecs[i].r);
      checkOutput($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expData,
                  vecs[i].expCount, vecs[i].expShift, vecs[i].expCaps, 1'b0);
    end

    // Five letters into a depth-4 FIFO, then a simultaneous push and pop when full.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, ovCodes[i], (i == 5));
      checkOutput($sformatf("ovf%0d", i), 1'b1, ovHead[i], ovCount[i], 1'b0, 1'b0, (i >= 4));
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput($sformatf("drain%0d", i), (i < 3), drHead[i], 3 - i, 1'b0, 1'b0, 1'b1);
    end

    applyStimulus(1'b1, 8'h12, 1'b0);
    applyStimulus(1'b1, 8'hF0, 1'b0);
    doReset("reset_mid_break");
    @(negedge clk);
    applyStimulus(1'b1, 8'h1C, 1'b0);
    checkOutput("after_reset_prefix", 1'b1, 8'h61, 1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("after_reset_pop", 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 9) < 7, pool[$urandom_range(0, 19)],
                    $urandom_range(0, 9) < 3);
      checkModel($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
